// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl
//   SPI slave front-end for the single-port RAM. Deserialises (WORD_W+2)-bit
//   MOSI frames into RAM command words and, for read-data commands, shifts
//   the RAM's response byte out on MISO. One SPI bit per clk while selected.
//
// Ports
//   clk       system clock
//   rst_n     synchronous, active-low reset
//   ss_n      slave select, active-low; rising level aborts/ends the frame
//   mosi      serial data in, MSB first
//   miso      serial data out, MSB first; 0 when not transmitting
//   rx_data   assembled command word, bits [WORD_W+1:WORD_W] are the command
//   rx_valid  one-cycle strobe when rx_data has been updated
//   tx_data   read data from RAM, sampled once when tx_valid is seen
//   tx_valid  RAM read data valid (level)
module spi_slave_ctrl #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [WORD_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 2);

  // rx_cnt counts data bits after the command MSB; RX_DONE marks frame complete.
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] RX_DONE = CNT_W'(WORD_W + 1);
  // tx_cnt: 0 waiting for tx_valid, 1..WORD_W-1 shifting, WORD_W final edge,
  // TX_DONE byte sent and tx_valid ignored until deselect.
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] TX_DONE = CNT_W'(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    rx_cnt, rx_cnt_next;
  logic [CNT_W-1:0]    tx_cnt, tx_cnt_next;
  logic [WORD_W:0]     rx_shift, rx_shift_next;
  logic [WORD_W-1:0]   tx_shift, tx_shift_next;
  logic [WORD_W+1:0]   rx_data_next;
  logic                rx_valid_next;
  logic                miso_next;
  logic                rd_addr_done, rd_addr_done_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt       <= '0;
      tx_cnt       <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      miso         <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      rx_cnt       <= rx_cnt_next;
      tx_cnt       <= tx_cnt_next;
      rx_shift     <= rx_shift_next;
      tx_shift     <= tx_shift_next;
      rx_data      <= rx_data_next;
      rx_valid     <= rx_valid_next;
      miso         <= miso_next;
      rd_addr_done <= rd_addr_done_next;
    end
  end

  always_comb begin
    state_next        = state;
    rx_cnt_next       = rx_cnt;
    tx_cnt_next       = tx_cnt;
    rx_shift_next     = rx_shift;
    tx_shift_next     = tx_shift;
    rx_data_next      = rx_data;
    rx_valid_next     = 1'b0;
    miso_next         = 1'b0;
    rd_addr_done_next = rd_addr_done;

    unique case (state)
      IDLE: begin
        rx_cnt_next   = '0;
        tx_cnt_next   = '0;
        rx_shift_next = '0;
        tx_shift_next = '0;
        if (!ss_n) begin
          state_next = CHK_CMD;
        end
      end

      CHK_CMD: begin
        rx_shift_next = {rx_shift[WORD_W-1:0], mosi};
        if (!mosi) begin
          state_next = WRITE;
        end else if (rd_addr_done) begin
          state_next = READ_DATA;
        end else begin
          state_next = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (rx_cnt != RX_DONE) begin
          rx_shift_next = {rx_shift[WORD_W-1:0], mosi};
          rx_cnt_next   = rx_cnt + CNT_W'(1);
          if (rx_cnt == RX_LAST) begin
            rx_data_next  = {rx_shift, mosi};
            rx_valid_next = 1'b1;
            if (state == READ_ADD) begin
              rd_addr_done_next = 1'b1;
            end
          end
        end else if (state == READ_DATA) begin
          // The MSB goes straight to miso on the tx_valid edge so the first
          // bit appears one cycle after the sample, not two.
          if (tx_cnt == '0) begin
            if (tx_valid) begin
              miso_next     = tx_data[WORD_W-1];
              tx_shift_next = {tx_data[WORD_W-2:0], 1'b0};
              tx_cnt_next   = CNT_W'(1);
            end
          end else if (tx_cnt < TX_LAST) begin
            miso_next     = tx_shift[WORD_W-1];
            tx_shift_next = {tx_shift[WORD_W-2:0], 1'b0};
            tx_cnt_next   = tx_cnt + CNT_W'(1);
          end else if (tx_cnt == TX_LAST) begin
            tx_cnt_next       = TX_DONE;
            rd_addr_done_next = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Deselect overrides everything above: abort discards the partial frame
    // or byte while leaving rx_data and rd_addr_done untouched.
    if (state != IDLE && ss_n) begin
      state_next        = IDLE;
      rx_cnt_next       = '0;
      tx_cnt_next       = '0;
      rx_shift_next     = '0;
      tx_shift_next     = '0;
      rx_data_next      = rx_data;
      rx_valid_next     = 1'b0;
      miso_next         = 1'b0;
      rd_addr_done_next = rd_addr_done;
    end
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave front-end that sequences the single-port RAM block. It deserialises MOSI frames into 10-bit command/data words for the RAM (`rx_data`/`rx_valid`). For read-data commands it captures the RAM's 8-bit response (`tx_data`/`tx_valid`) and serialises it onto MISO. It sits between the external SPI pins and the RAM and is the only agent that issues RAM commands.

## Interface
- WORD_W, 8, RAM data/address width; rx frame width is WORD_W+2 (command bits [WORD_W+1:WORD_W]).
- clk  input  1  system clock; one SPI bit per clk while selected.
- rst_n  input  1  reset, synchronous, active-low.
- ss_n  input  1  slave select, active-low; frame boundary.
- mosi  input  1  serial data in, MSB first, sampled on clk rising edge.
- miso  output  1  serial data out, MSB first; 0 when not transmitting.
- rx_data  output  WORD_W+2  assembled command word to RAM.
- rx_valid  output  1  one-cycle strobe: rx_data holds a complete frame.
- tx_data  input  WORD_W  read data from RAM.
- tx_valid  input  1  RAM read data valid (level).

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `rd_addr_done`: set on completed READ_ADD frame; cleared on completed READ_DATA transmission and by reset.
- Transitions:
  - IDLE -> CHK_CMD when ss_n=0.
  - CHK_CMD: ss_n=1 -> IDLE. Otherwise the sampled mosi is captured as rx_data[9] (command MSB).
    - mosi=0 -> WRITE.
    - mosi=1 and rd_addr_done=0 -> READ_ADD.
    - mosi=1 and rd_addr_done=1 -> READ_DATA.
  - WRITE / READ_ADD / READ_DATA: ss_n=1 -> IDLE from any of these states, at any time.
- Bit capture: a 4-bit counter captures bits 8..0 over the 9 cycles following CHK_CMD.
- Bits are forwarded verbatim. The command bits are not checked against the state; the RAM decodes rx_data[9:8].
- Frame completion: after the last bit, rx_data is registered and rx_valid pulses once. rx_data holds until the next completed frame.
- WRITE / READ_ADD after completion: further MOSI bits are ignored until ss_n=1.
- READ_DATA after rx_valid:
  - Wait for tx_valid=1; sample it once.
  - Load tx_data into the shift register and shift out WORD_W bits MSB first.
  - Then drive miso=0 and ignore tx_valid until ss_n=1.
  - If ss_n rises before all bits are shifted, the transmission is discarded and rd_addr_done stays 1.
- Aborted frame (ss_n=1 before the last bit): no rx_valid, rx_data unchanged, flag unchanged, counters cleared.
- Reset values (rst_n=0 at a clk edge): state=IDLE, rx_data=0, rx_valid=0, miso=0, rd_addr_done=0, counters=0, shift register=0. Reset has priority over every other event, including mid-frame.

## Timing
- Edge E0 samples ss_n=0 in IDLE; the state is CHK_CMD for the next cycle.
- Edge E1 samples bit 9. Edges E2..E10 sample bits 8..0.
- rx_valid=1 in the cycle after E10 (between E10 and E11), exactly one cycle. Latency from the last bit to the strobe is 1 clk.
- tx_valid first sampled high at edge Ek (Ek ≥ E11):
  - miso = tx_data[7] after Ek, tx_data[6] after Ek+1, …, tx_data[0] after Ek+7.
  - miso = 0 from Ek+8.
- tx_valid already high at E11 gives Ek = E11.
- ss_n sampled high at any edge: state=IDLE and miso=0 in the following cycle.
- A new frame may start on the edge right after the IDLE cycle. Back-to-back frames need at least one ss_n-high sample.
- tx_data is sampled only at Ek. Later changes to tx_data do not affect the byte being sent.

## Test plan
- Write address: ss_n low, send 10'b00_0001_0100 -> rx_data=10'h014, rx_valid high exactly one cycle after bit 0, state stays WRITE until ss_n high.
- Write data: send 10'b01_1010_0101 -> rx_data=10'h1A5, one rx_valid pulse; rd_addr_done stays 0.
- Read sequence:
  - Send 10'b10_0001_0100 -> state READ_ADD, rx_data=10'h214, rd_addr_done=1.
  - New frame 10'b11_0000_0000 -> state READ_DATA, rx_data=10'h300.
  - Drive tx_data=8'hA5, tx_valid=1 two cycles later -> miso bits 1,0,1,0,0,1,0,1 on consecutive cycles, then 0; rd_addr_done=0 at the end.
- Read data without address: reset, then send 10'b11_xxxx_xxxx -> state READ_ADD (not READ_DATA).
- Abort: ss_n high after 5 bits of a write frame -> no rx_valid, rx_data keeps its previous value, IDLE next cycle; the following full frame decodes correctly.
- Reset mid-transmission: rst_n=0 during the 4th miso bit -> next cycle miso=0, rx_valid=0, rx_data=0, state=IDLE, rd_addr_done=0.
